pkt_channel_arbiter: RTL and testbench

Shares one head/tail/valid framed packet channel between NREQ requesters. Grants are round-robin and locked per packet, from the head beat to the tail beat. The packet-state FSM uses the same IDLE/HEAD/DATA/TAIL encoding as the existing channel FSM, so the block sits directly in front of that channel. A beat-count watchdog forces release when a tail never arrives.

---
 rtl/pkt_channel_arbiter.sv | 137 +++++++++++++
 tb/tb_pkt_channel_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pkt_channel_arbiter.sv
// Round-robin, packet-locked arbiter for a head/tail/valid framed channel.
// A beat-count watchdog forces the grant to be released if a tail never arrives.
module pkt_channel_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int MAX_PKT_LEN = 16,
  parameter int CNTW        = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_head,
  input  logic [NREQ-1:0] req_tail,
  output logic [NREQ-1:0] req_ready,
  output logic            out_valid,
  output logic            out_head,
  output logic            out_tail,
  input  logic            out_ready,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic [1:0]      state,
  output logic            abort
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    DATA = 2'b10,
    TAIL = 2'b11
  } state_t;

  state_t          cur_state, nxt_state;
  logic [NREQ-1:0] grant_nxt;
  logic [IDW-1:0]  grant_id_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [IDW-1:0]  pick;
  logic [IDW:0]    slot;
  logic [CNTW-1:0] beat_cnt, beat_cnt_nxt;
  logic            abort_nxt;
  logic            found;
  logic            active;
  logic            xfer;

  assign state  = cur_state;
  assign active = (cur_state == HEAD) || (cur_state == DATA);
  assign xfer   = out_valid & out_ready;

  always_comb begin
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    req_ready = '0;
    if (active) begin
      out_valid           = req_valid[grant_id];
      out_head            = req_head[grant_id];
      out_tail            = req_tail[grant_id];
      req_ready[grant_id] = out_ready;
    end
  end

  // Search upward from the slot after the previous owner, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    slot  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      slot = {1'b0, ptr} + (IDW+1)'(k);
      if (slot >= (IDW+1)'(NREQ)) slot = slot - (IDW+1)'(NREQ);
      if (!found && req_valid[slot[IDW-1:0]] && req_head[slot[IDW-1:0]]) begin
        found = 1'b1;
        pick  = slot[IDW-1:0];
      end
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    abort_nxt    = 1'b0;
    case (cur_state)
      IDLE: begin
        if (found) begin
          nxt_state    = HEAD;
          grant_nxt    = NREQ'(1) << pick;
          grant_id_nxt = pick;
          beat_cnt_nxt = '0;
        end
      end
      HEAD: begin
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNTW'(1);
          nxt_state    = out_tail ? TAIL : DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNTW'(1);
          if (out_tail) begin
            nxt_state = TAIL;
          end else if (beat_cnt_nxt == CNTW'(MAX_PKT_LEN)) begin
            nxt_state = TAIL;
            abort_nxt = 1'b1;
          end
        end
      end
      TAIL: begin
        // grant_id is kept so software can still see who owned the last packet.
        ptr_nxt   = grant_id;
        grant_nxt = '0;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= IDLE;
      grant     <= '0;
      grant_id  <= '0;
      ptr       <= IDW'(NREQ-1);
      beat_cnt  <= '0;
      abort     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      grant     <= grant_nxt;
      grant_id  <= grant_id_nxt;
      ptr       <= ptr_nxt;
      beat_cnt  <= beat_cnt_nxt;
      abort     <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_pkt_channel_arbiter.sv
// Randomized bench for pkt_channel_arbiter, checked every cycle against a
// packet-level model (owner, beats so far, release pending).
module tb_pkt_channel_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int MAXL = 4;
  localparam int CNTW = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req_valid, req_head, req_tail, req_ready;
  logic            out_valid, out_head, out_tail, out_ready;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [1:0]      state;
  logic            abort;

  int checks   = 0;
  int failures = 0;

  // Model: owner index (-1 none), beats moved, release-cycle pending, etc.
  int m_owner, m_beats, m_ptr, m_last;
  bit m_release, m_abort;

  pkt_channel_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_PKT_LEN(MAXL), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail), .req_ready(req_ready),
    .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail), .out_ready(out_ready),
    .grant(grant), .grant_id(grant_id), .state(state), .abort(abort)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_beats   = 0;
    m_ptr     = NREQ - 1;
    m_last    = 0;
    m_release = 0;
    m_abort   = 0;
  endtask

  task automatic apply_stimulus(input int mode);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      case (mode)
        1: begin req_valid[i] = 1'b1; req_head[i] = 1'b1; req_tail[i] = 1'b1; end
        2: begin req_valid[i] = 1'b1; req_head[i] = 1'b1; req_tail[i] = 1'b0; end
        default: begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_head[i]  = $urandom_range(0, 1) == 1;
          req_tail[i]  = ($urandom_range(0, 5) == 0);
        end
      endcase
    end
    out_ready = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (mode == 0) reset = ($urandom_range(0, 149) == 0);
  endtask

  task automatic check_cycle();
    int              exp_state;
    bit              active;
    logic [NREQ-1:0] exp_grant, exp_ready;
    logic            ev, eh, et;
    if (m_release)        exp_state = 3;
    else if (m_owner < 0) exp_state = 0;
    else if (m_beats == 0) exp_state = 1;
    else                  exp_state = 2;
    active    = (m_owner >= 0) && !m_release;
    exp_grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    ev = active ? req_valid[m_owner] : 1'b0;
    eh = active ? req_head[m_owner]  : 1'b0;
    et = active ? req_tail[m_owner]  : 1'b0;
    exp_ready = (active && out_ready) ? NREQ'(1 << m_owner) : '0;
    check_output("state",     32'(state),     32'(exp_state));
    check_output("grant",     32'(grant),     32'(exp_grant));
    check_output("grant_id",  32'(grant_id),  32'(m_last));
    check_output("abort",     32'(abort),     32'(m_abort));
    check_output("out_valid", 32'(out_valid), 32'(ev));
    check_output("out_head",  32'(out_head),  32'(eh));
    check_output("out_tail",  32'(out_tail),  32'(et));
    check_output("req_ready", 32'(req_ready), 32'(exp_ready));
    check_output("onehot",    32'($onehot0(grant)), 32'd1);
  endtask

  task automatic model_advance();
    int w;
    if (reset) begin
      model_reset();
    end else if (m_release) begin
      m_ptr     = m_last;
      m_owner   = -1;
      m_release = 0;
      m_abort   = 0;
    end else if (m_owner < 0) begin
      m_abort = 0;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[c] && req_head[c]) w = c;
      end
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_beats = 0;
      end
    end else begin
      m_abort = 0;
      if (req_valid[m_owner] && out_ready) begin
        m_beats++;
        if (req_tail[m_owner]) begin
          m_release = 1;
        end else if (m_beats == MAXL) begin
          m_release = 1;
          m_abort   = 1;
        end
      end
    end
  endtask

  task automatic run_phase(input int mode, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      apply_stimulus(mode);
      @(negedge clock);
      check_cycle();
      model_advance();
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_head  = '0;
    req_tail  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    run_phase(1, 40);
    run_phase(0, 500);
    run_phase(2, 80);
    run_phase(0, 400);
    run_phase(1, 20);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
